mb_mode_saver: RTL and testbench

- Parametrised successor to the fixed three-mode 16x16 luma saver.
- Accepts one macroblock's SAD vector over a valid/ready handshake and picks the minimum-SAD mode with a sequential comparator.
- Records the chosen mode in an internal per-MB mode table, then streams the chosen mode's residues into an external frame residue memory through a raster write port.
- Sits after the intra-prediction SAD/residue generators and ahead of transform/entropy stages.

---
 rtl/mb_saver_pkg.sv | 33 +++
 rtl/mb_mode_table.sv | 30 +++
 rtl/mb_mode_saver.sv | 196 +++++++++++++++++++
 tb/tb_mb_mode_saver.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mb_saver_pkg.sv
`default_nettype none
// ============================================================================
// mb_saver_pkg : shared state enum, mode type and sizing helpers for mb_mode_saver
// Revision     : 1.0
// ============================================================================
package mb_saver_pkg;

  function automatic int clog2w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int mbs_per_row(input int frame_w, input int mb_w);
    return frame_w / mb_w;
  endfunction

  function automatic int mb_count(input int frame_w, input int frame_h,
                                  input int mb_w, input int mb_h);
    return (frame_w / mb_w) * (frame_h / mb_h);
  endfunction

  localparam int DEF_NUM_MODES = 4;
  localparam int DEF_MODE_W    = clog2w(DEF_NUM_MODES);

  typedef logic [DEF_MODE_W-1:0] mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    STREAM = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mb_mode_table.sv
`default_nettype none
// ============================================================================
// mb_mode_table : single-write / single-read registered RAM holding one mode per MB
// Revision      : 1.0
// ============================================================================
module mb_mode_table #(
  parameter int DEPTH = 3600,
  parameter int AW    = 12,
  parameter int DW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Read samples the array before this edge's write lands: old data on collision.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/mb_mode_saver.sv
`default_nettype none
// ============================================================================
// mb_mode_saver : picks the min-SAD mode per MB, records it, streams its residues
//                 to frame memory. Optional usage counters: MB_MODE_STATS_EN.
// Revision      : 1.0
// ============================================================================
module mb_mode_saver
  import mb_saver_pkg::*;
#(
  parameter  int NUM_MODES   = 4,
  parameter  int SAD_W       = 16,
  parameter  int PIX_W       = 8,
  parameter  int FRAME_W     = 1280,
  parameter  int FRAME_H     = 720,
  parameter  int MB_W        = 16,
  parameter  int MB_H        = 16,
  localparam int MBS_PER_ROW = mbs_per_row(FRAME_W, MB_W),
  localparam int MB_COUNT    = mb_count(FRAME_W, FRAME_H, MB_W, MB_H),
  localparam int MBN_W       = clog2w(MB_COUNT),
  localparam int ADDR_W      = clog2w(FRAME_W * FRAME_H),
  localparam int MODE_W      = clog2w(NUM_MODES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SAD_W-1:0]  sads [NUM_MODES],
  input  logic [MBN_W-1:0]  mbnumber,
  output logic              mode_valid,
  output logic [MODE_W-1:0] mode,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [PIX_W-1:0]  res_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              done,
  output logic              err,
  input  logic [MBN_W-1:0]  mt_raddr,
  output logic [MODE_W-1:0] mt_rdata
`ifdef MB_MODE_STATS_EN
  ,
  output logic [MBN_W:0]    mode_cnt [NUM_MODES],
  input  logic              stats_clr
`endif
);

  localparam int MBX_W   = clog2w(MBS_PER_ROW);
  localparam int MBY_W   = clog2w(FRAME_H / MB_H);
  localparam int PX_W    = clog2w(MB_W);
  localparam int PY_W    = clog2w(MB_H);
  localparam int LOG_MBW = $clog2(MB_W);
  localparam int LOG_MBH = $clog2(MB_H);
  localparam logic [MODE_W-1:0] K_LAST  = MODE_W'(NUM_MODES - 1);
  localparam logic [PX_W-1:0]   PX_LAST = PX_W'(MB_W - 1);
  localparam logic [PY_W-1:0]   PY_LAST = PY_W'(MB_H - 1);

  state_t            state, state_nx;
  logic [SAD_W-1:0]  sads_q [NUM_MODES];
  logic [MBN_W-1:0]  mbn_q;
  logic [MBX_W-1:0]  mb_x;
  logic [MBY_W-1:0]  mb_y;
  logic [MODE_W-1:0] k, best, cmp_best;
  logic [PX_W-1:0]   px;
  logic [PY_W-1:0]   py;
  logic              mb_legal, last_cmp, last_px, tbl_we;
  logic [ADDR_W:0]   row_full;
  logic [ADDR_W-1:0] addr_next;

  assign mb_legal = {1'b0, mbnumber} < (MBN_W+1)'(MB_COUNT);
  // k=0 compares mode 0 against itself, giving a setup cycle before the real compares.
  assign cmp_best = (sads_q[k] < sads_q[best]) ? k : best;
  assign last_cmp = (state == SEARCH) && (k == K_LAST);
  assign last_px  = (state == STREAM) && res_valid && (px == PX_LAST) && (py == PY_LAST);
  assign tbl_we   = last_cmp && reset;

  assign row_full  = ((ADDR_W+1)'(mb_y) << LOG_MBH) + (ADDR_W+1)'(py);
  assign addr_next = ADDR_W'(row_full * (ADDR_W+1)'(FRAME_W)
                             + ((ADDR_W+1)'(mb_x) << LOG_MBW) + (ADDR_W+1)'(px));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    mode_valid = 1'b0;
    res_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && mb_legal) state_nx = SEARCH;
      end
      SEARCH: begin
        if (k == K_LAST) state_nx = STREAM;
      end
      STREAM: begin
        mode_valid = 1'b1;
        res_ready  = 1'b1;
        if (last_px) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode    <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      k       <= '0;
      best    <= '0;
      px      <= '0;
      py      <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!mb_legal) begin
              err <= 1'b1;
            end else begin
              sads_q <= sads;
              mbn_q  <= mbnumber;
              mb_x   <= MBX_W'({1'b0, mbnumber} % (MBN_W+1)'(MBS_PER_ROW));
              mb_y   <= MBY_W'({1'b0, mbnumber} / (MBN_W+1)'(MBS_PER_ROW));
              best   <= '0;
              k      <= '0;
            end
          end
        end
        SEARCH: begin
          best <= cmp_best;
          k    <= k + 1'b1;
          if (k == K_LAST) begin
            mode <= cmp_best;
            px   <= '0;
            py   <= '0;
          end
        end
        STREAM: begin
          if (res_valid) begin
            wr_en   <= 1'b1;
            wr_data <= res_data;
            wr_addr <= addr_next;
            if (px == PX_LAST) begin
              px <= '0;
              py <= py + 1'b1;
              if (py == PY_LAST) done <= 1'b1;
            end else begin
              px <= px + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  mb_mode_table #(
    .DEPTH (MB_COUNT),
    .AW    (MBN_W),
    .DW    (MODE_W)
  ) u_mode_table (
    .clk   (clk),
    .we    (tbl_we),
    .waddr (mbn_q),
    .wdata (cmp_best),
    .raddr (mt_raddr),
    .rdata (mt_rdata)
  );

`ifdef MB_MODE_STATS_EN
  always_ff @(posedge clk) begin
    for (int m = 0; m < NUM_MODES; m++) begin
      if (!reset || stats_clr) begin
        mode_cnt[m] <= '0;
      end else if (tbl_we && (cmp_best == MODE_W'(m)) && (mode_cnt[m] != '1)) begin
        mode_cnt[m] <= mode_cnt[m] + 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mb_mode_saver.sv
`default_nettype none
// ============================================================================
// tb_mb_mode_saver : randomized self-checking bench for mb_mode_saver
// Revision         : 1.0
// ============================================================================
module tb_mb_mode_saver;

  localparam int NM     = 4;
  localparam int SAD_W  = 16;
  localparam int PIX_W  = 8;
  localparam int FW     = 1280;
  localparam int FH     = 720;
  localparam int MBW    = 16;
  localparam int MBH    = 16;
  localparam int MBPR   = FW / MBW;
  localparam int MBC    = MBPR * (FH / MBH);
  localparam int MBN_W  = $clog2(MBC);
  localparam int ADDR_W = $clog2(FW * FH);
  localparam int MODE_W = $clog2(NM);
  localparam int NPIX   = MBW * MBH;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [SAD_W-1:0]  sads [NM];
  logic [MBN_W-1:0]  mbnumber = '0;
  logic              mode_valid;
  logic [MODE_W-1:0] mode;
  logic              res_valid = 1'b0;
  logic              res_ready;
  logic [PIX_W-1:0]  res_data = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              done;
  logic              err;
  logic [MBN_W-1:0]  mt_raddr = '0;
  logic [MODE_W-1:0] mt_rdata;
`ifdef MB_MODE_STATS_EN
  logic [MBN_W:0]    mode_cnt [NM];
  logic              stats_clr = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] wq_addr [$];
  logic [PIX_W-1:0]  wq_data [$];
  logic [PIX_W-1:0]  eq_data [$];
  int done_cnt   = 0;
  int done_alone = 0;
  int err_cnt    = 0;
  int exp_tbl [int];

  mb_mode_saver dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sads       (sads),
    .mbnumber   (mbnumber),
    .mode_valid (mode_valid),
    .mode       (mode),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .done       (done),
    .err        (err),
    .mt_raddr   (mt_raddr),
    .mt_rdata   (mt_rdata)
`ifdef MB_MODE_STATS_EN
    ,
    .mode_cnt   (mode_cnt),
    .stats_clr  (stats_clr)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
    if (done) begin
      done_cnt++;
      if (!wr_en) done_alone++;
    end
    if (err) err_cnt++;
  end

  // Reference: lowest index among those holding the minimum SAD.
  function automatic int ref_mode();
    int minv = int'(sads[0]);
    int r = 0;
    for (int m = 1; m < NM; m++) if (int'(sads[m]) < minv) minv = int'(sads[m]);
    for (int m = NM - 1; m >= 0; m--) if (int'(sads[m]) == minv) r = m;
    return r;
  endfunction

  function automatic int ref_addr(input int n, input int i);
    int x = (n % MBPR) * MBW + (i % MBW);
    int y = (n / MBPR) * MBH + (i / MBW);
    return y * FW + x;
  endfunction

  task automatic clear_obs();
    wq_addr.delete();
    wq_data.delete();
    done_cnt   = 0;
    done_alone = 0;
    err_cnt    = 0;
  endtask

  task automatic start_mb(input int n, output bit ok, output int exp_mode);
    int cyc = 0;
    bit rdy_bad = 0;
    exp_mode = ref_mode();
    @(negedge clk);
    clear_obs();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL start_in_ready mb=%0d: got %b want 1", n, in_ready);
    end
    mbnumber = MBN_W'(n);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (mode_valid !== 1'b1 && cyc < 20) begin
      if (in_ready !== 1'b0) rdy_bad = 1;
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (cyc != NM) begin
      n_fail++; $display("FAIL mode_valid_latency mb=%0d: got %0d want %0d", n, cyc, NM);
    end
    n_checks++;
    if (rdy_bad) begin
      n_fail++; $display("FAIL in_ready_during_search mb=%0d: got 1 want 0", n);
    end
    n_checks++;
    if (mode !== MODE_W'(exp_mode)) begin
      n_fail++; $display("FAIL chosen_mode mb=%0d: got %0d want %0d", n, mode, exp_mode);
    end
    ok = (mode_valid === 1'b1);
  endtask

  task automatic stream(input int nsamp, input int duty);
    int i = 0;
    int guard = 0;
    bit bad_ctl = 0;
    eq_data.delete();
    while (i < nsamp && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (res_ready !== 1'b1 || mode_valid !== 1'b1 || in_ready !== 1'b0) bad_ctl = 1;
      res_valid = ($urandom_range(99) < duty);
      res_data  = PIX_W'($urandom_range(255));
      if (res_valid) begin
        eq_data.push_back(res_data);
        i++;
      end
    end
    @(negedge clk);
    res_valid = 1'b0;
    n_checks++;
    if (bad_ctl || i != nsamp) begin
      n_fail++; $display("FAIL stream_handshake: bad_ctl=%0d sent=%0d want bad_ctl=0 sent=%0d", bad_ctl, i, nsamp);
    end
  endtask

  task automatic check_writes(input int n, input int cnt);
    int bad = -1;
    n_checks++;
    if (wq_addr.size() != cnt) begin
      n_fail++; $display("FAIL write_count mb=%0d: got %0d want %0d", n, wq_addr.size(), cnt);
    end else begin
      for (int i = 0; i < cnt; i++)
        if (bad < 0 && (wq_addr[i] !== ADDR_W'(ref_addr(n, i)) || wq_data[i] !== eq_data[i])) bad = i;
      n_checks++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL write_seq mb=%0d idx=%0d: got addr=%0d data=%0d want addr=%0d data=%0d",
                 n, bad, wq_addr[bad], wq_data[bad], ref_addr(n, bad), eq_data[bad]);
      end
    end
  endtask

  task automatic check_mb_end(input int n);
    n_checks++;
    if (done_cnt != 1 || done_alone != 0) begin
      n_fail++; $display("FAIL done_pulse mb=%0d: got count=%0d alone=%0d want 1/0", n, done_cnt, done_alone);
    end
    n_checks++;
    if (mode_valid !== 1'b0 || res_ready !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_stream_ctl mb=%0d: got mv=%b rr=%b ir=%b want 0 0 1", n, mode_valid, res_ready, in_ready);
    end
  endtask

  task automatic read_tbl(input int a, input int exp);
    @(negedge clk);
    mt_raddr = MBN_W'(a);
    @(posedge clk); #1;
    n_checks++;
    if (mt_rdata !== MODE_W'(exp)) begin
      n_fail++; $display("FAIL mode_table[%0d]: got %0d want %0d", a, mt_rdata, exp);
    end
  endtask

  task automatic full_mb(input int n, input int duty, output int m);
    bit ok;
    start_mb(n, ok, m);
    if (ok) begin
      stream(NPIX, duty);
      check_writes(n, NPIX);
      check_mb_end(n);
      exp_tbl[n] = m;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || mode_valid !== 1'b0 || res_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctl: got ir=%b mv=%b rr=%b want 1 0 0", in_ready, mode_valid, res_ready);
    end
    n_checks++;
    if (wr_en !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses: got wr=%b done=%b err=%b want 0 0 0", wr_en, done, err);
    end
    n_checks++;
    if (mode !== '0 || wr_addr !== '0 || wr_data !== '0) begin
      n_fail++; $display("FAIL reset_data: got mode=%0d addr=%0d data=%0d want 0 0 0", mode, wr_addr, wr_data);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_tie_mb0();
    int m;
    sads[0] = 16'd40; sads[1] = 16'd12; sads[2] = 16'd12; sads[3] = 16'd90;
    full_mb(0, 100, m);
  endtask

  task automatic test_mb81();
    int m;
    sads[0] = 16'd50; sads[1] = 16'd60; sads[2] = 16'd70; sads[3] = 16'd5;
    full_mb(81, 100, m);
    n_checks++;
    if (wq_addr.size() != NPIX || wq_addr[0] !== ADDR_W'(ref_addr(81, 0))
        || wq_addr[NPIX-1] !== ADDR_W'(ref_addr(81, NPIX - 1))) begin
      n_fail++; $display("FAIL mb81_corners: got %0d writes want first=%0d last=%0d",
                         wq_addr.size(), ref_addr(81, 0), ref_addr(81, NPIX - 1));
    end
    read_tbl(81, 3);
  endtask

  task automatic test_gaps_random();
    int m;
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < NM; s++) sads[s] = SAD_W'($urandom_range(20));
      full_mb(int'($urandom_range(MBC - 1)), 50, m);
    end
  endtask

  task automatic test_err();
    @(negedge clk);
    clear_obs();
    mbnumber = MBN_W'(MBC);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (err !== 1'b1 || in_ready !== 1'b1 || mode_valid !== 1'b0) begin
      n_fail++; $display("FAIL err_pulse: got err=%b ir=%b mv=%b want 1 1 0", err, in_ready, mode_valid);
    end
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (err_cnt != 1 || wq_addr.size() != 0 || mode_valid !== 1'b0) begin
      n_fail++; $display("FAIL err_aftermath: got errs=%0d writes=%0d mv=%b want 1 0 0", err_cnt, wq_addr.size(), mode_valid);
    end
  endtask

  task automatic test_reset_mid_stream();
    bit ok;
    int m;
    int n = 200;
    for (int s = 0; s < NM; s++) sads[s] = SAD_W'($urandom_range(1000));
    start_mb(n, ok, m);
    if (ok) begin
      exp_tbl[n] = m;
      stream(100, 100);
      reset     = 1'b0;
      res_valid = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (wr_en !== 1'b0 || in_ready !== 1'b1 || mode_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_mid_stream: got wr=%b ir=%b mv=%b want 0 1 0", wr_en, in_ready, mode_valid);
      end
      @(negedge clk);
      reset     = 1'b1;
      res_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_writes(n, 100);
    end
  endtask

  task automatic test_table_readback();
    foreach (exp_tbl[a]) read_tbl(a, exp_tbl[a]);
  endtask

`ifdef MB_MODE_STATS_EN
  task automatic test_stats();
    int picks [5] = '{2, 2, 0, 2, 1};
    int cnt [NM];
    int m;
    for (int s = 0; s < NM; s++) cnt[s] = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j < 5; j++) begin
      for (int s = 0; s < NM; s++) sads[s] = 16'd200;
      sads[picks[j]] = 16'd7;
      full_mb(j + 10, 100, m);
      cnt[picks[j]]++;
    end
    for (int s = 0; s < NM; s++) begin
      n_checks++;
      if (mode_cnt[s] !== (MBN_W+1)'(cnt[s])) begin
        n_fail++; $display("FAIL mode_cnt[%0d]: got %0d want %0d", s, mode_cnt[s], cnt[s]);
      end
    end
    @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    for (int s = 0; s < NM; s++) begin
      n_checks++;
      if (mode_cnt[s] !== '0) begin
        n_fail++; $display("FAIL mode_cnt_clr[%0d]: got %0d want 0", s, mode_cnt[s]);
      end
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    for (int s = 0; s < NM; s++) sads[s] = '0;
    test_reset();
    test_tie_mb0();
    test_mb81();
    test_gaps_random();
    test_err();
    test_reset_mid_stream();
    test_table_readback();
`ifdef MB_MODE_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
